cordic_phase_sink: RTL and testbench

Downstream consumer of the vectoring-mode CORDIC phase output. It re-times a sample-valid strobe through the CORDIC pipeline latency and captures the aligned phase words. It computes the wrapped phase step between consecutive samples and averages 2^LOG2_N steps into a frequency estimate. The result is held in a one-entry output register with a valid/ready handshake.

---
 rtl/cordic_phase_sink_if.sv | 30 +++
 rtl/cordic_phase_sink.sv | 150 +++++++++++++++
 tb/tb_cordic_phase_sink.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_phase_sink_if.sv
// Handshake bundle for cordic_phase_sink.
//   in_valid  : a sample pair enters the CORDIC this cycle
//   clear     : synchronous flush of the averaging window and valid pipeline
//   phase_in  : CORDIC z_out, signed degrees (9 integer + 7 fraction bits)
//   out_valid : freq_out holds an unconsumed result
//   out_ready : consumer accepts the result
//   freq_out  : average phase step per sample, same format as phase_in
//   overrun   : one-cycle pulse, a completed result was dropped
// master = producer/consumer environment, slave = the sink itself.
interface cordic_phase_sink_if #(
  parameter int unsigned PHASE_WIDTH = 16
);
  logic                   in_valid;
  logic                   clear;
  logic [PHASE_WIDTH-1:0] phase_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [PHASE_WIDTH-1:0] freq_out;
  logic                   overrun;

  modport master (
    output in_valid, clear, phase_in, out_ready,
    input  out_valid, freq_out, overrun
  );

  modport slave (
    input  in_valid, clear, phase_in, out_ready,
    output out_valid, freq_out, overrun
  );
endinterface

// File: rtl/cordic_phase_sink.sv
// Consumer of a vectoring-mode CORDIC phase output.
// Re-times in_valid through the CORDIC latency, captures the aligned phase words, forms the
// wrapped phase step between consecutive samples and averages 2^LOG2_N steps into a frequency
// estimate, held in a one-entry valid/ready output register.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-low reset
//   bus : cordic_phase_sink_if.slave (in_valid, clear, phase_in, out_ready in;
//         out_valid, freq_out, overrun out)
// LATENCY must be at least 2 and LOG2_N at least 1.
module cordic_phase_sink #(
  parameter int unsigned PHASE_WIDTH = 16,
  parameter int unsigned LATENCY     = 15,
  parameter int unsigned LOG2_N      = 3
) (
  input logic                clk,
  input logic                rst,
  cordic_phase_sink_if.slave bus
);

  localparam int unsigned DiffW = PHASE_WIDTH + 2;
  localparam int unsigned AccW  = PHASE_WIDTH + LOG2_N + 2;
  // 180.0 and 360.0 degrees with 7 fraction bits
  localparam logic signed [DiffW-1:0] HalfTurn = DiffW'(23040);
  localparam logic signed [DiffW-1:0] FullTurn = DiffW'(46080);

  typedef enum logic [0:0] {StFirst, StAcc} state_e;

  logic [LATENCY-1:0]     vline_q, vline_d;
  state_e                 state_q, state_d;
  logic [PHASE_WIDTH-1:0] prev_q, prev_d;
  logic signed [AccW-1:0] sum_q, sum_d;
  logic [LOG2_N-1:0]      cnt_q, cnt_d;
  logic                   out_valid_q, out_valid_d;
  logic [PHASE_WIDTH-1:0] freq_q, freq_d;
  logic                   overrun_q, overrun_d;

  logic                    av;
  logic signed [DiffW-1:0] diff_raw;
  logic signed [DiffW-1:0] diff;
  logic signed [AccW-1:0]  sum_new;
  logic [PHASE_WIDTH-1:0]  result;
  logic                    win_done;
  logic                    accept;

  assign av = vline_q[LATENCY-1];

  // Valid delay line; clear also drops an in_valid arriving in the same cycle.
  always_comb begin
    vline_d = {vline_q[LATENCY-2:0], bus.in_valid};
    if (bus.clear) begin
      vline_d = '0;
    end
  end

  // Wrapped step: one correction only, landing in [-180, +180) for legal inputs.
  always_comb begin
    diff_raw = DiffW'($signed(bus.phase_in)) - DiffW'($signed(prev_q));
    diff     = diff_raw;
    if (diff_raw >= HalfTurn) begin
      diff = diff_raw - FullTurn;
    end else if (diff_raw < -HalfTurn) begin
      diff = diff_raw + FullTurn;
    end
    sum_new = sum_q + AccW'(diff);
    // Arithmetic shift gives floor division by 2^LOG2_N.
    result  = PHASE_WIDTH'(sum_new >>> LOG2_N);
  end

  assign win_done = !bus.clear && av && (state_q == StAcc) && (cnt_q == '1);
  assign accept   = out_valid_q && bus.out_ready;

  // Window FSM
  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    if (bus.clear) begin
      state_d = StFirst;
      sum_d   = '0;
      cnt_d   = '0;
    end else if (av) begin
      unique case (state_q)
        StFirst: begin
          prev_d  = bus.phase_in;
          sum_d   = '0;
          cnt_d   = '0;
          state_d = StAcc;
        end
        StAcc: begin
          // prev carries across windows so consecutive windows share a boundary sample.
          prev_d = bus.phase_in;
          if (cnt_q == '1) begin
            sum_d = '0;
            cnt_d = '0;
          end else begin
            sum_d = sum_new;
            cnt_d = cnt_q + LOG2_N'(1);
          end
        end
        default: state_d = StFirst;
      endcase
    end
  end

  // One-entry output register; a result arriving while the slot is held is dropped.
  always_comb begin
    out_valid_d = out_valid_q;
    freq_d      = freq_q;
    overrun_d   = 1'b0;
    if (win_done) begin
      if (!out_valid_q || accept) begin
        out_valid_d = 1'b1;
        freq_d      = result;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (accept) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vline_q     <= '0;
      state_q     <= StFirst;
      prev_q      <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      freq_q      <= '0;
      overrun_q   <= 1'b0;
    end else begin
      vline_q     <= vline_d;
      state_q     <= state_d;
      prev_q      <= prev_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      freq_q      <= freq_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.freq_out  = freq_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_cordic_phase_sink.sv
// Self-checking bench for cordic_phase_sink. Each scenario builds a per-cycle plan (in_valid,
// out_ready, clear, reset and the phase of every sample), a reference model derives the
// expected outputs from sample lists with plain integer arithmetic, and the DUT is run and
// compared cycle by cycle.
module tb_cordic_phase_sink;
  localparam int PW   = 16;
  localparam int LAT  = 15;
  localparam int L2N  = 3;
  localparam int N    = 8;
  localparam int MAXC = 256;

  logic clk = 1'b0;
  logic rst;

  cordic_phase_sink_if #(.PHASE_WIDTH(PW)) bus ();

  cordic_phase_sink #(
    .PHASE_WIDTH(PW),
    .LATENCY    (LAT),
    .LOG2_N     (L2N)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit          vin_a [MAXC];
  bit          rdy_a [MAXC];
  bit          clr_a [MAXC];
  bit          rst_a [MAXC];
  int          av_idx[MAXC];
  int          samp_ph[MAXC];
  int          nsamp;
  logic        exp_v [MAXC];
  logic        exp_o [MAXC];
  logic [15:0] exp_f [MAXC];
  logic        obs_v [MAXC];
  logic        obs_o [MAXC];
  logic [15:0] obs_f [MAXC];

  // Wrap an absolute phase (1/128 degree units) into [-180, +180).
  function automatic int wrap_ph(input int p);
    int r = p;
    while (r >= 23040) r -= 46080;
    while (r < -23040) r += 46080;
    return r;
  endfunction

  // Single-correction wrapped step.
  function automatic int wrap_step(input int d);
    if (d >= 23040) return d - 46080;
    if (d < -23040) return d + 46080;
    return d;
  endfunction

  // floor(s / N), truncated to 16 bits.
  function automatic logic [15:0] avg_floor(input int s);
    int q = s / N;
    if (s < 0 && q * N != s) q = q - 1;
    return 16'(q);
  endfunction

  task automatic clear_plan();
    for (int c = 0; c < MAXC; c++) begin
      vin_a[c] = 0; rdy_a[c] = 0; clr_a[c] = 0; rst_a[c] = 0; av_idx[c] = -1;
      samp_ph[c] = 0;
    end
    nsamp = 0;
  endtask

  // Samples must be added in increasing cycle order.
  task automatic add_sample(input int c, input int ph);
    vin_a[c] = 1;
    samp_ph[nsamp] = ph;
    if (c + LAT < MAXC) av_idx[c + LAT] = nsamp;
    nsamp++;
  endtask

  // Reference model: walk the aligned samples, split the stream at clear/reset, average every
  // N wrapped steps, then play the results through a one-slot valid/ready register.
  task automatic build_model(input int n);
    bit seeded = 0;
    int prev = 0, sum = 0, cnt = 0, d;
    bit comp[MAXC];
    int cval[MAXC];
    bit killed;
    bit ev = 0, eo = 0, eo_n;
    logic [15:0] ef = 16'h0000;
    for (int c = 0; c < n; c++) begin
      comp[c] = 0; cval[c] = 0;
      if (clr_a[c] || rst_a[c]) begin
        seeded = 0; cnt = 0; sum = 0;
      end else if (av_idx[c] >= 0) begin
        killed = 0;
        for (int j = c - LAT; j < c; j++) if (clr_a[j] || rst_a[j]) killed = 1;
        if (!killed) begin
          if (!seeded) begin
            seeded = 1; prev = samp_ph[av_idx[c]]; cnt = 0; sum = 0;
          end else begin
            d = wrap_step(samp_ph[av_idx[c]] - prev);
            prev = samp_ph[av_idx[c]];
            sum += d;
            cnt++;
            if (cnt == N) begin
              comp[c] = 1; cval[c] = sum; cnt = 0; sum = 0;
            end
          end
        end
      end
    end
    for (int c = 0; c < n; c++) begin
      if (rst_a[c]) begin
        ev = 0; ef = 16'h0000; eo = 0;
        exp_v[c] = 0; exp_f[c] = 16'h0000; exp_o[c] = 0;
      end else begin
        exp_v[c] = ev; exp_f[c] = ef; exp_o[c] = eo;
        eo_n = 0;
        if (comp[c]) begin
          if (!ev || rdy_a[c]) begin
            ev = 1; ef = avg_floor(cval[c]);
          end else begin
            eo_n = 1;
          end
        end else if (ev && rdy_a[c]) begin
          ev = 0;
        end
        eo = eo_n;
      end
    end
  endtask

  // Drive the plan; inputs change 1 time unit after the rising edge, outputs are sampled on
  // the falling edge. Cycles without an aligned sample carry random phase garbage.
  task automatic run_dut(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      rst           = ~rst_a[c];
      bus.in_valid  = vin_a[c];
      bus.clear     = clr_a[c];
      bus.out_ready = rdy_a[c];
      bus.phase_in  = (av_idx[c] >= 0) ? 16'(samp_ph[av_idx[c]]) : 16'($urandom);
      @(negedge clk);
      obs_v[c] = bus.out_valid;
      obs_f[c] = bus.freq_out;
      obs_o[c] = bus.overrun;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0; bus.clear = 1'b0; bus.out_ready = 1'b0; bus.phase_in = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'($urandom); bus.phase_in = 16'($urandom);
      bus.out_ready = 1'($urandom); bus.clear = 1'b0;
      @(negedge clk);
      checks += 3;
      if (bus.out_valid !== 1'b0) begin
        errors++; $display("FAIL reset out_valid got %b want 0", bus.out_valid);
      end
      if (bus.freq_out !== 16'h0000) begin
        errors++; $display("FAIL reset freq_out got %h want 0000", bus.freq_out);
      end
      if (bus.overrun !== 1'b0) begin
        errors++; $display("FAIL reset overrun got %b want 0", bus.overrun);
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    bus.in_valid = 1'b0;
    clear_plan();
    for (int c = 0; c < 24; c++) begin
      if (c == 0 || $urandom_range(0, 1) == 1) add_sample(c, $urandom_range(0, 46079) - 23040);
      rdy_a[c] = 1'($urandom);
    end
    run_dut(24);
    for (int c = 0; c < 24; c++) begin
      checks += 2;
      if (obs_v[c] !== 1'b0) begin
        errors++; $display("FAIL early_valid cycle %0d got %b want 0", c, obs_v[c]);
      end
      if (obs_o[c] !== 1'b0) begin
        errors++; $display("FAIL early_overrun cycle %0d got %b want 0", c, obs_o[c]);
      end
    end
  endtask

  task automatic test_ramp();
    clear_plan();
    for (int k = 0; k < 9; k++) add_sample(k, k * 1280);
    for (int c = 0; c < 40; c++) rdy_a[c] = 1;
    build_model(40);
    run_dut(40);
    for (int c = 0; c < 40; c++) begin
      checks += 3;
      if (obs_v[c] !== exp_v[c]) begin
        errors++; $display("FAIL ramp out_valid cycle %0d got %b want %b", c, obs_v[c], exp_v[c]);
      end
      if (obs_o[c] !== exp_o[c]) begin
        errors++; $display("FAIL ramp overrun cycle %0d got %b want %b", c, obs_o[c], exp_o[c]);
      end
      if (obs_f[c] !== exp_f[c]) begin
        errors++; $display("FAIL ramp freq_out cycle %0d got %h want %h", c, obs_f[c], exp_f[c]);
      end
    end
    checks++;
    if (obs_v[23] !== 1'b0 || obs_v[24] !== 1'b1 || obs_v[25] !== 1'b0 || obs_f[24] !== 16'h0500)
    begin
      errors++;
      $display("FAIL ramp_timing got v23=%b v24=%b v25=%b f=%h want 0 1 0 0500",
               obs_v[23], obs_v[24], obs_v[25], obs_f[24]);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] want;
    int deg;
    for (int dir = 0; dir < 2; dir++) begin
      do_reset();
      clear_plan();
      for (int k = 0; k < 9; k++) begin
        deg = (dir == 0) ? 170 + 20 * k : -170 - 20 * k;
        add_sample(k, wrap_ph(deg * 128));
      end
      for (int c = 0; c < 40; c++) rdy_a[c] = 1;
      build_model(40);
      run_dut(40);
      for (int c = 0; c < 40; c++) begin
        checks += 3;
        if (obs_v[c] !== exp_v[c]) begin
          errors++; $display("FAIL wrap out_valid cycle %0d got %b want %b", c, obs_v[c], exp_v[c]);
        end
        if (obs_o[c] !== exp_o[c]) begin
          errors++; $display("FAIL wrap overrun cycle %0d got %b want %b", c, obs_o[c], exp_o[c]);
        end
        if (obs_f[c] !== exp_f[c]) begin
          errors++; $display("FAIL wrap freq_out cycle %0d got %h want %h", c, obs_f[c], exp_f[c]);
        end
      end
      want = (dir == 0) ? 16'h0A00 : 16'hF600;
      checks++;
      if (obs_v[24] !== 1'b1 || obs_f[24] !== want) begin
        errors++; $display("FAIL wrap_dir%0d got v=%b f=%h want 1 %h", dir, obs_v[24], obs_f[24],
                           want);
      end
    end
  endtask

  task automatic test_backpressure();
    int ph = 0;
    clear_plan();
    add_sample(0, 0);
    // Each window gets its own step so held, dropped and replacement results are distinct.
    for (int k = 1; k < 41; k++) begin
      ph = wrap_ph(ph + 1280 + 128 * ((k - 1) / N));
      add_sample(k, ph);
    end
    for (int c = 0; c < 70; c++) rdy_a[c] = (c >= 44 && c <= 47) || c >= 55;
    build_model(70);
    run_dut(70);
    for (int c = 0; c < 70; c++) begin
      checks += 3;
      if (obs_v[c] !== exp_v[c]) begin
        errors++; $display("FAIL bp out_valid cycle %0d got %b want %b", c, obs_v[c], exp_v[c]);
      end
      if (obs_o[c] !== exp_o[c]) begin
        errors++; $display("FAIL bp overrun cycle %0d got %b want %b", c, obs_o[c], exp_o[c]);
      end
      if (obs_f[c] !== exp_f[c]) begin
        errors++; $display("FAIL bp freq_out cycle %0d got %h want %h", c, obs_f[c], exp_f[c]);
      end
    end
    checks++;
    if (obs_o[32] !== 1'b1 || obs_o[33] !== 1'b0 || obs_f[43] !== 16'h0500) begin
      errors++; $display("FAIL bp_drop got o32=%b o33=%b f43=%h want 1 0 0500",
                         obs_o[32], obs_o[33], obs_f[43]);
    end
    checks++;
    if (obs_v[55] !== 1'b1 || obs_v[56] !== 1'b1 || obs_f[56] !== 16'h0700) begin
      errors++; $display("FAIL bp_swap got v55=%b v56=%b f56=%h want 1 1 0700",
                         obs_v[55], obs_v[56], obs_f[56]);
    end
  endtask

  task automatic test_floor();
    clear_plan();
    for (int k = 0; k < 8; k++) add_sample(k, 0);
    add_sample(8, -1);
    clr_a[30] = 1;
    for (int k = 0; k < 9; k++) add_sample(31 + k, (k < 8) ? k : 7);
    for (int c = 0; c < 60; c++) rdy_a[c] = 1;
    build_model(60);
    run_dut(60);
    for (int c = 0; c < 60; c++) begin
      checks += 3;
      if (obs_v[c] !== exp_v[c]) begin
        errors++; $display("FAIL floor out_valid cycle %0d got %b want %b", c, obs_v[c], exp_v[c]);
      end
      if (obs_o[c] !== exp_o[c]) begin
        errors++; $display("FAIL floor overrun cycle %0d got %b want %b", c, obs_o[c], exp_o[c]);
      end
      if (obs_f[c] !== exp_f[c]) begin
        errors++; $display("FAIL floor freq_out cycle %0d got %h want %h", c, obs_f[c], exp_f[c]);
      end
    end
    checks++;
    if (obs_f[24] !== 16'hFFFF || obs_v[55] !== 1'b1 || obs_f[55] !== 16'h0000) begin
      errors++; $display("FAIL floor_values got f24=%h v55=%b f55=%h want ffff 1 0000",
                         obs_f[24], obs_v[55], obs_f[55]);
    end
  endtask

  task automatic test_clear_mid();
    int s0 = $urandom_range(0, 46079) - 23040;
    clear_plan();
    for (int k = 0; k < 4; k++) add_sample(k, $urandom_range(0, 46079) - 23040);
    clr_a[20] = 1;
    for (int k = 0; k < 9; k++) add_sample(21 + k, wrap_ph(s0 + 640 * k));
    for (int c = 0; c < 55; c++) rdy_a[c] = 1;
    build_model(55);
    run_dut(55);
    for (int c = 0; c < 55; c++) begin
      checks += 3;
      if (obs_v[c] !== exp_v[c]) begin
        errors++; $display("FAIL clear out_valid cycle %0d got %b want %b", c, obs_v[c], exp_v[c]);
      end
      if (obs_o[c] !== exp_o[c]) begin
        errors++; $display("FAIL clear overrun cycle %0d got %b want %b", c, obs_o[c], exp_o[c]);
      end
      if (obs_f[c] !== exp_f[c]) begin
        errors++; $display("FAIL clear freq_out cycle %0d got %h want %h", c, obs_f[c], exp_f[c]);
      end
    end
    checks++;
    if (obs_v[44] !== 1'b0 || obs_v[45] !== 1'b1 || obs_f[45] !== 16'h0280) begin
      errors++; $display("FAIL clear_result got v44=%b v45=%b f45=%h want 0 1 0280",
                         obs_v[44], obs_v[45], obs_f[45]);
    end
  endtask

  task automatic test_rst_mid();
    int s0 = $urandom_range(0, 46079) - 23040;
    clear_plan();
    for (int k = 0; k < 13; k++) add_sample(k, k * 768);
    rst_a[30] = 1;
    for (int k = 0; k < 9; k++) add_sample(31 + k, wrap_ph(s0 + 640 * k));
    for (int c = 0; c < 65; c++) rdy_a[c] = (c >= 50);
    build_model(65);
    run_dut(65);
    for (int c = 0; c < 65; c++) begin
      checks += 3;
      if (obs_v[c] !== exp_v[c]) begin
        errors++; $display("FAIL rst out_valid cycle %0d got %b want %b", c, obs_v[c], exp_v[c]);
      end
      if (obs_o[c] !== exp_o[c]) begin
        errors++; $display("FAIL rst overrun cycle %0d got %b want %b", c, obs_o[c], exp_o[c]);
      end
      if (obs_f[c] !== exp_f[c]) begin
        errors++; $display("FAIL rst freq_out cycle %0d got %h want %h", c, obs_f[c], exp_f[c]);
      end
    end
    checks++;
    if (obs_v[29] !== 1'b1 || obs_v[30] !== 1'b0 || obs_f[30] !== 16'h0000 ||
        obs_v[55] !== 1'b1 || obs_f[55] !== 16'h0280) begin
      errors++; $display("FAIL rst_result got v29=%b v30=%b f30=%h v55=%b f55=%h want 1 0 0 1 0280",
                         obs_v[29], obs_v[30], obs_f[30], obs_v[55], obs_f[55]);
    end
  endtask

  task automatic test_random();
    int n = 250;
    clear_plan();
    for (int c = 0; c < n; c++) begin
      if (c + LAT < n && $urandom_range(0, 9) < 7) add_sample(c, $urandom_range(0, 55807) - 23040);
      rdy_a[c] = ($urandom_range(0, 1) == 1);
      clr_a[c] = ($urandom_range(0, 59) == 0);
    end
    build_model(n);
    run_dut(n);
    for (int c = 0; c < n; c++) begin
      checks += 3;
      if (obs_v[c] !== exp_v[c]) begin
        errors++; $display("FAIL rand out_valid cycle %0d got %b want %b", c, obs_v[c], exp_v[c]);
      end
      if (obs_o[c] !== exp_o[c]) begin
        errors++; $display("FAIL rand overrun cycle %0d got %b want %b", c, obs_o[c], exp_o[c]);
      end
      if (obs_f[c] !== exp_f[c]) begin
        errors++; $display("FAIL rand freq_out cycle %0d got %h want %h", c, obs_f[c], exp_f[c]);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    bus.in_valid = 1'b0; bus.clear = 1'b0; bus.out_ready = 1'b0; bus.phase_in = '0;
    test_reset();
    do_reset();
    test_ramp();
    test_wrap();
    do_reset();
    test_backpressure();
    do_reset();
    test_floor();
    do_reset();
    test_clear_mid();
    do_reset();
    test_rst_mid();
    do_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
